// File: rtl/instr_sequencer.sv
// Instruction sequencer: input FIFO, instruction register and 2-bit step counter
// feeding the combinational step controller of the 10-bit processor.
module instr_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_instr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     IRin,
  input  logic                     Clr,
  output logic [WIDTH-1:0]         INSTR,
  output logic [1:0]               TIME,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     done,
  output logic [7:0]               retired,
  output logic                     stall
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {
    StStep0 = 2'd0,
    StStep1 = 2'd1,
    StStep2 = 2'd2,
    StStep3 = 2'd3
  } step_e;

  step_e            step_q, step_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] instr_q;
  logic             done_q;
  logic [7:0]       retired_q;

  logic full, empty, push, pop, retire;

  assign full   = (count_q == CntW'(DEPTH));
  assign empty  = (count_q == '0);
  assign push   = in_valid && !full;
  // No bypass: a pop only sees entries already committed to storage.
  assign pop    = (step_q == StStep0) && IRin && !empty;
  assign retire = (step_q != StStep0) && Clr;

  // Step counter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= StStep0;
    end else begin
      step_q <= step_d;
    end
  end

  always_comb begin
    step_d = step_q;
    unique case (step_q)
      StStep0: step_d = pop ? StStep1 : StStep0;
      StStep1: step_d = Clr ? StStep0 : StStep2;
      StStep2: step_d = Clr ? StStep0 : StStep3;
      // Without Clr this is a protocol fault wrap, not a retire.
      StStep3: step_d = StStep0;
      default: step_d = StStep0;
    endcase
  end

  always_comb begin
    TIME       = step_q;
    INSTR      = instr_q;
    fifo_count = count_q;
    in_ready   = !full;
    stall      = (step_q == StStep0) && empty;
    done       = done_q;
    retired    = retired_q;
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      instr_q   <= '0;
      done_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      count_q <= count_d;
      done_q  <= retire;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
        instr_q  <= mem[rd_ptr_q];
      end
      if (retire) begin
        retired_q <= retired_q + 8'd1;
      end
    end
  end

  // Storage is not reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= in_instr;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: scoreboard FIFO model plus a small
// step-controller model that raises IRin at step 0 and Clr at a per-opcode step.
module tb_instr_sequencer;

  localparam int DEPTH = 4;
  localparam logic [9:0] ADD  = 10'b0001000010;
  localparam logic [9:0] ADDI = 10'b1000000101;
  localparam logic [9:0] LOAD = 10'b0000010001;
  localparam logic [9:0] INV  = 10'b0100100000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] in_instr;
  logic       in_valid;
  logic       in_ready;
  logic       IRin;
  logic       Clr;
  logic [9:0] INSTR;
  logic [1:0] TIME;
  logic [2:0] fifo_count;
  logic       done;
  logic [7:0] retired;
  logic       stall;

  instr_sequencer #(
    .DEPTH(DEPTH),
    .WIDTH(10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_instr  (in_instr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .IRin      (IRin),
    .Clr       (Clr),
    .INSTR     (INSTR),
    .TIME      (TIME),
    .fifo_count(fifo_count),
    .done      (done),
    .retired   (retired),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [9:0] exp_q[$];
  int         m_time;
  logic [9:0] m_instr;
  logic       m_done;
  logic [7:0] m_retired;
  logic       last_push;
  logic       ctrl_en;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int step_for(input logic [9:0] w);
    if (w == ADD || w == ADDI) return 3;
    if (w == LOAD) return 1;
    if (w == INV) return 2;
    return int'(w % 10'd3) + 1;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_time    = 0;
    m_instr   = '0;
    m_done    = 1'b0;
    m_retired = '0;
  endtask

  task automatic check_all();
    check_eq("TIME", 32'(TIME), 32'(m_time));
    check_eq("INSTR", 32'(INSTR), 32'(m_instr));
    check_eq("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
    check_eq("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
    check_eq("stall", 32'(stall), 32'(m_time == 0 && exp_q.size() == 0));
    check_eq("done", 32'(done), 32'(m_done));
    check_eq("retired", 32'(retired), 32'(m_retired));
  endtask

  task automatic ctrl_update();
    if (ctrl_en) begin
      IRin = (TIME == 2'd0);
      Clr  = (TIME != 2'd0) && (int'(TIME) == step_for(INSTR));
    end
  endtask

  // Advance the model with the inputs about to be sampled, clock, then compare.
  task automatic tick();
    logic       push, pop;
    logic [9:0] w;
    w    = '0;
    push = in_valid && (exp_q.size() < DEPTH);
    pop  = (m_time == 0) && IRin && (exp_q.size() != 0);
    m_done = (m_time != 0) && Clr;
    if (m_done) m_retired = m_retired + 8'd1;
    if (m_time == 0) m_time = pop ? 1 : 0;
    else if (Clr || m_time == 3) m_time = 0;
    else m_time = m_time + 1;
    if (pop) begin
      w = exp_q.pop_front();
      m_instr = w;
    end
    if (push) exp_q.push_back(in_instr);
    last_push = push;
    @(posedge clk);
    #1;
    check_all();
    if (pop) check_eq("fetch", 32'(INSTR), 32'(w));
    ctrl_update();
  endtask

  task automatic idle_inputs();
    ctrl_en  = 1'b0;
    in_valid = 1'b0;
    IRin     = 1'b0;
    Clr      = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    ctrl_en  = 1'b1;
    ctrl_update();
    while (!(exp_q.size() == 0 && m_time == 0) && n < 200) begin
      tick();
      n++;
    end
    check_eq("drain_ok", 32'(exp_q.size() == 0 && m_time == 0), 32'd1);
    idle_inputs();
  endtask

  initial begin
    int n, stalls, pushed, maxc;
    logic [7:0] r0;
    logic wrapped;
    rst_n    = 1'b0;
    in_instr = '0;
    last_push = 1'b0;
    idle_inputs();
    model_reset();
    #7;
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single ADD, Clr at step 3
    ctrl_en  = 1'b1;
    ctrl_update();
    in_valid = 1'b1;
    in_instr = ADD;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_eq("single_retired", 32'(retired), 32'd1);
    check_eq("single_instr", 32'(INSTR), 32'h042);
    idle_inputs();

    // Back-to-back LOAD / INV / ADDI
    in_valid = 1'b1;
    in_instr = LOAD; tick();
    in_instr = INV;  tick();
    in_instr = ADDI; tick();
    in_valid = 1'b0;
    r0 = retired;
    ctrl_en = 1'b1;
    ctrl_update();
    tick();
    n = 1;
    stalls = int'(stall);
    while (n < 20) begin
      tick();
      n++;
      if (retired == r0 + 8'd3) break;
      stalls += int'(stall);
    end
    check_eq("b2b_cycles", 32'(n), 32'd9);
    check_eq("b2b_stalls", 32'(stalls), 32'd0);
    check_eq("b2b_retired", 32'(retired), 32'(r0 + 8'd3));
    idle_inputs();

    // Full FIFO: fifth push refused
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_instr = 10'h200 + 10'(i);
      tick();
      if (i == 3) check_eq("full_ready_after4", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    check_eq("full_count", 32'(fifo_count), 32'd4);
    IRin = 1'b1;
    tick();
    IRin = 1'b0;
    check_eq("ready_after_pop", 32'(in_ready), 32'd1);
    drain();

    // Pointer wrap: 9 words interleaved with fetches
    pushed = 0;
    maxc = 0;
    n = 0;
    ctrl_en = 1'b1;
    ctrl_update();
    while (!(pushed == 9 && exp_q.size() == 0 && m_time == 0) && n < 300) begin
      in_valid = (pushed < 9) && (exp_q.size() < 3);
      in_instr = 10'h100 + 10'(pushed * 7);
      tick();
      if (last_push) pushed++;
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
      n++;
    end
    check_eq("wrap_pushed", 32'(pushed), 32'd9);
    check_eq("wrap_max_le_depth", 32'(maxc <= DEPTH), 32'd1);
    idle_inputs();

    // Protocol faults: IRin mid-instruction, step-3 wrap without Clr
    in_valid = 1'b1;
    in_instr = 10'h155;
    tick();
    in_valid = 1'b0;
    IRin = 1'b1;
    tick();
    IRin = 1'b0;
    tick();
    in_valid = 1'b1;
    in_instr = 10'h2aa;
    IRin = 1'b1;
    tick();
    check_eq("irin_ignored_instr", 32'(INSTR), 32'h155);
    check_eq("irin_ignored_time", 32'(TIME), 32'd3);
    idle_inputs();
    r0 = retired;
    tick();
    check_eq("fault_wrap_time", 32'(TIME), 32'd0);
    check_eq("fault_retired", 32'(retired), 32'(r0));
    check_eq("fault_no_done", 32'(done), 32'd0);
    drain();
    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    check_eq("clr_step0_no_done", 32'(done), 32'd0);
    tick();

    // Retired counter wraps 255 -> 0
    wrapped = 1'b0;
    ctrl_en = 1'b1;
    ctrl_update();
    in_valid = 1'b1;
    in_instr = LOAD;
    for (int i = 0; i < 2000; i++) begin
      r0 = retired;
      tick();
      if (r0 == 8'd255 && done) begin
        check_eq("retired_wrap", 32'(retired), 32'd0);
        wrapped = 1'b1;
        break;
      end
    end
    check_eq("retired_wrap_seen", 32'(wrapped), 32'd1);
    drain();

    // Asynchronous reset with TIME=2 and three entries queued
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_instr = 10'h300 + 10'(i);
      tick();
    end
    in_valid = 1'b0;
    IRin = 1'b1;
    tick();
    IRin = 1'b0;
    tick();
    check_eq("pre_rst_time", 32'(TIME), 32'd2);
    check_eq("pre_rst_count", 32'(fifo_count), 32'd3);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    check_eq("rst_instr", 32'(INSTR), 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Recovery after reset
    in_valid = 1'b1;
    in_instr = ADDI;
    tick();
    drain();
    check_eq("post_rst_retired", 32'(retired), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Upstream stage of the 10-bit processor control path. Buffers instructions from the user input port in a small FIFO and owns the instruction register and 2-bit step counter. Drives `INSTR` and `TIME` into the combinational step controller and consumes that controller's `IRin` (fetch) and `Clr` (end-of-instruction) outputs, so each instruction executes in 2–4 steps and the next one is fetched automatically.

## Interface
- `DEPTH`, default 4: FIFO entries. Must be a power of 2, at least 2.
- `WIDTH`, default 10: instruction width.
- `clk  in  1`: single clock. All state updates on the rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `in_instr  in  WIDTH`: instruction word offered by the user input.
- `in_valid  in  1`: `in_instr` is valid this cycle.
- `in_ready  out  1`: FIFO can accept a word. Equal to `!full`.
- `IRin  in  1`: fetch request from the controller.
- `Clr  in  1`: end-of-instruction from the controller.
- `INSTR  out  WIDTH`: instruction register contents.
- `TIME  out  2`: current step (0–3).
- `fifo_count  out  $clog2(DEPTH)+1`: number of occupied FIFO entries.
- `done  out  1`: one-cycle pulse when an instruction retires.
- `retired  out  8`: count of retired instructions. Wraps from 255 to 0.
- `stall  out  1`: high when `TIME==0` and the FIFO is empty.

## Operation
- **FIFO push**
  - A push occurs when `in_valid && in_ready`.
  - Circular buffer with read and write pointers of `$clog2(DEPTH)` bits that wrap modulo `DEPTH`, plus an occupancy counter.
  - `full` = `fifo_count==DEPTH`. `empty` = `fifo_count==0`.
- **FIFO pop (fetch)**
  - A pop occurs when `TIME==0 && IRin && !empty`.
  - The head entry is written into `INSTR`, `TIME` becomes 1, and the read pointer advances.
- **Step counter**
  - `TIME==0`:
    - Advances to 1 only on a pop.
    - Otherwise holds at 0 and `stall` is high.
    - `Clr` is ignored at step 0.
  - `TIME` in {1, 2, 3}:
    - If `Clr` is high, the next `TIME` is 0, `done` pulses high for the following cycle, and `retired` increments.
    - Otherwise `TIME` increments.
    - `TIME==3` without `Clr` wraps to 0 as a protocol fault. This is not a retire: no `done` pulse and no `retired` increment.
- **Ignored requests**
  - `IRin` when `TIME!=0` is ignored.
  - `INSTR` changes only on a pop. It holds through execution and while stalled.
- **Simultaneous push and pop**
  - Both take effect and `fifo_count` is unchanged.
  - When full, `in_ready` is low, so a push is not accepted even in a pop cycle.
  - When empty, there is no bypass: a word pushed in cycle n can be popped no earlier than cycle n+1.
- **Reset** (asynchronous, any time, including mid-instruction):
  - `TIME`=0, `INSTR`=0, pointers=0, `fifo_count`=0, `done`=0, `retired`=0.
  - Derived outputs at reset: `in_ready`=1, `stall`=1.
  - FIFO storage contents need not be cleared.
  - The in-flight instruction is discarded.

## Timing
- All outputs are registered or decoded from registers only. There is no combinational path from `in_valid`, `IRin` or `Clr` to any output.
- **Push-to-fetch latency**, FIFO empty and `TIME==0`:
  - Push sampled at edge E.
  - `fifo_count`=1 after E.
  - Pop at edge E+1, so `INSTR` and `TIME`=1 are visible after E+1.
- **Instruction length** depends on the step at which the controller raises `Clr`:
  - `Clr` at step 1: 2 cycles (LOAD, COPY).
  - `Clr` at step 2: 3 cycles (INV, FLP).
  - `Clr` at step 3: 4 cycles (ALU and immediate ops).
- **Back-to-back**: with the FIFO non-empty, the next fetch happens in the cycle immediately after the retiring step. There are no idle cycles.
- `done` is high during the `TIME==0` cycle that follows the retire edge.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-step with `TIME`=2 and `fifo_count`=3 → immediately `TIME`=0, `INSTR`=0, `fifo_count`=0, `in_ready`=1, `stall`=1, `retired`=0.
- **Single instruction.** Push 10'b0001000010 (ADD) with the controller model raising `Clr` at step 3 → `TIME` sequence 0,1,2,3,0. `INSTR` holds 0x042 from step 1 onward. `done` pulses once and `retired`=1.
- **Back-to-back mix.** Push LOAD (`Clr` at step 1), INV (`Clr` at step 2), ADDI 10'b1000000101 (`Clr` at step 3) → 2+3+4 = 9 cycles from the first fetch to the final `TIME`=0. No `stall` between instructions and `retired`=3.
- **Full FIFO.** With `IRin` held low, push 5 words at `DEPTH`=4 → `in_ready` drops after the 4th push and the 5th word is not accepted. `fifo_count`=4. After one pop, `in_ready`=1.
- **Pointer wrap.** Push 9 distinct words interleaved with fetches, keeping 1–3 entries occupied → words are fetched in exact push order across pointer wrap, and `fifo_count` never exceeds 4.
- **Protocol faults.** `IRin`=1 at `TIME`=2 leaves `INSTR` unchanged. `Clr`=1 at `TIME`=0 with an empty FIFO gives no `done` pulse. `TIME`=3 with no `Clr` wraps to 0 with `retired` unchanged. Driving `retired` past 255 wraps it to 0.
